// File: rtl/demux_vc_pkg.sv
// Shared definitions for the two-virtual-channel demultiplexer.
package demux_vc_pkg;

   localparam int unsigned DATA_W       = 6;
   localparam int unsigned DEPTH_DEF    = 4;
   localparam int unsigned AF_LEVEL_DEF = 3;

   typedef enum logic {
      VC0 = 1'b0,
      VC1 = 1'b1
   } vc_e;

endpackage : demux_vc_pkg

// File: rtl/demux_vc_fifo_vc.sv
// Per-channel synchronous first-word-fall-through FIFO with
// full, almost-full and sticky overflow flags.
module fifo_vc #(
   parameter int unsigned DATA_W   = 6,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned AF_LEVEL = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              full,
   output logic              almost_full,
   output logic              overflow
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_valid;
   logic              r_full;
   logic              r_af;
   logic              r_ovf;

   logic              w_do_push;
   logic              w_do_pop;
   logic              w_drop;
   logic [CNT_W-1:0]  w_count_nxt;

   // A pop on a full FIFO frees the slot the concurrent push needs.
   always_comb begin
      w_do_pop    = pop & r_valid;
      w_do_push   = push & (~r_full | w_do_pop);
      w_drop      = push & ~w_do_push;
      w_count_nxt = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_full   <= 1'b0;
         r_af     <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         r_valid <= (w_count_nxt != '0);
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
         r_af    <= (w_count_nxt >= CNT_W'(AF_LEVEL));
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // Storage is not reset; the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   assign data_out    = r_valid ? r_mem[r_rd_ptr] : '0;
   assign valid_out   = r_valid;
   assign full        = r_full;
   assign almost_full = r_af;
   assign overflow    = r_ovf;

endmodule : fifo_vc

// File: rtl/demux_vc.sv
// Receive end of the VC0/VC1 muxed link: steers tagged words into
// one FWFT FIFO per virtual channel.
module demux_vc
   import demux_vc_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned AF_LEVEL = AF_LEVEL_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              vc_sel,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop_VC0,
   input  logic              pop_VC1,
   output logic [DATA_W-1:0] data_out_VC0,
   output logic [DATA_W-1:0] data_out_VC1,
   output logic              valid_out_VC0,
   output logic              valid_out_VC1,
   output logic              full_VC0,
   output logic              full_VC1,
   output logic              almost_full_VC0,
   output logic              almost_full_VC1,
   output logic              overflow_VC0,
   output logic              overflow_VC1
);

   logic w_push_vc0;
   logic w_push_vc1;

   assign w_push_vc0 = valid_in & (vc_e'(vc_sel) == VC0);
   assign w_push_vc1 = valid_in & (vc_e'(vc_sel) == VC1);

   fifo_vc #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) u_fifo_vc0 (
      .clk         (clk),
      .reset       (reset),
      .push        (w_push_vc0),
      .pop         (pop_VC0),
      .data_in     (data_in),
      .data_out    (data_out_VC0),
      .valid_out   (valid_out_VC0),
      .full        (full_VC0),
      .almost_full (almost_full_VC0),
      .overflow    (overflow_VC0)
   );

   fifo_vc #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) u_fifo_vc1 (
      .clk         (clk),
      .reset       (reset),
      .push        (w_push_vc1),
      .pop         (pop_VC1),
      .data_in     (data_in),
      .data_out    (data_out_VC1),
      .valid_out   (valid_out_VC1),
      .full        (full_VC1),
      .almost_full (almost_full_VC1),
      .overflow    (overflow_VC1)
   );

endmodule : demux_vc
